// File: rtl/simple_bit_ops_arb.sv
// Two-requester round-robin arbiter feeding a single-issue bitwise/reduction unit (IDLE -> EXEC -> RESP).
// Define SIMPLE_BIT_OPS_ARB_PERF_EN to add per-requester 16-bit handshake counters perf_cnt0/perf_cnt1.
module simple_bit_ops_arb #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err
`ifdef SIMPLE_BIT_OPS_ARB_PERF_EN
  ,
  output logic [15:0]      perf_cnt0,
  output logic [15:0]      perf_cnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_rr;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;

  logic             w_req_any;
  logic             w_grant;
  logic             w_gnt_id;
  logic             w_hs;

  // Returns {err, data}; reductions are zero-extended to WIDTH, b is ignored for unary ops.
  function automatic logic [WIDTH:0] f_compute(input logic [2:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] data;
    logic             err;
    data = '0;
    err  = 1'b0;
    case (op)
      3'd0:    data = a & b;
      3'd1:    data = a ^ b;
      3'd2:    data = a | b;
      3'd3:    data = ~a;
      3'd4:    data = WIDTH'(&a);
      3'd5:    data = WIDTH'(^a);
      3'd6:    data = WIDTH'(|a);
      default: err  = 1'b1;
    endcase
    return {err, data};
  endfunction

  // Ready is combinational in the grant cycle and forced low while reset is asserted.
  assign w_req_any  = req0_valid | req1_valid;
  assign w_grant    = reset & (r_state == S_IDLE) & w_req_any;
  assign w_gnt_id   = (req0_valid & req1_valid) ? r_rr : req1_valid;
  assign req0_ready = w_grant & ~w_gnt_id;
  assign req1_ready = w_grant & w_gnt_id;
  assign w_hs       = (r_state == S_RESP) & rsp_valid & rsp_ready;

  // Grant stage: operands are captured once and never re-sampled for this operation.
  always_ff @(posedge clock) begin
    if (w_grant) begin
      r_id <= w_gnt_id;
      r_op <= w_gnt_id ? req1_op : req0_op;
      r_a  <= w_gnt_id ? req1_a  : req0_a;
      r_b  <= w_gnt_id ? req1_b  : req0_b;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rr      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          {rsp_err, rsp_data} <= f_compute(r_op, r_a, r_b);
          rsp_id              <= r_id;
          rsp_valid           <= 1'b1;
          r_state             <= S_RESP;
        end
        S_RESP: begin
          // Priority passes to the requester that was not just served.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_rr      <= ~rsp_id;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SIMPLE_BIT_OPS_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_cnt0 <= 16'd0;
      perf_cnt1 <= 16'd0;
    end else if (w_hs) begin
      if (rsp_id) begin
        perf_cnt1 <= perf_cnt1 + 16'd1;
      end else begin
        perf_cnt0 <= perf_cnt0 + 16'd1;
      end
    end
  end
`else
  logic w_hs_unused;
  assign w_hs_unused = w_hs;
`endif

endmodule

// File: tb/tb_simple_bit_ops_arb.sv
// Randomized self-checking bench for simple_bit_ops_arb against a behavioural arbiter/ALU model.
module tb_simple_bit_ops_arb;
  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_id, rsp_err;
`ifdef SIMPLE_BIT_OPS_ARB_PERF_EN
  logic [15:0]  perf_cnt0, perf_cnt1;
`endif

  int   errors = 0;
  int   checks = 0;
  logic tb_rr  = 1'b0;

  simple_bit_ops_arb #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
`ifdef SIMPLE_BIT_OPS_ARB_PERF_EN
    , .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired: got=timeout required=finish");
    $fatal(1);
  end

  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic e);
    e = 1'b0;
    case (op)
      3'd0: d = a & b;
      3'd1: d = a ^ b;
      3'd2: d = a | b;
      3'd3: d = ~a;
      3'd4: d = W'(a == '1);
      3'd5: d = W'($countones(a) % 2);
      3'd6: d = W'(a != '0);
      default: begin d = '0; e = 1'b1; end
    endcase
  endtask

  // Drives one complete transaction and reports what was observed; comparisons are done by callers.
  task automatic run_one(input logic v0, input logic v1, input logic [2:0] op0, input logic [2:0] op1,
                         input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input int stall, input bit hold,
                         output logic g0, output logic g1, output bit early, output logic vld,
                         output logic [W-1:0] d, output logic id, output logic e, output bit ok);
    @(negedge clock);
    req0_valid = v0; req1_valid = v1;
    req0_op = op0; req0_a = a0; req0_b = b0;
    req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready = 1'b0;
    #1;
    g0 = req0_ready; g1 = req1_ready;
    @(negedge clock);
    if (!hold) begin
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      req0_op = 3'($urandom); req1_op = 3'($urandom);
      req0_a = W'($urandom); req0_b = W'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom);
    end
    #1;
    early = rsp_valid | req0_ready | req1_ready;
    @(negedge clock);
    #1;
    vld = rsp_valid; d = rsp_data; id = rsp_id; e = rsp_err;
    ok = !(req0_ready | req1_ready);
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_id !== id || rsp_err !== e ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) ok = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    if (rsp_valid !== 1'b0) ok = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    tb_rr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++;
      $display("FAIL reset_ready got=%b required=00", {req0_ready, req1_ready}); end
    checks++; if (rsp_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got=%b required=0", rsp_valid); end
    checks++; if ({rsp_data, rsp_id, rsp_err} !== '0) begin errors++;
      $display("FAIL reset_outputs got=%h/%b/%b required=0/0/0", rsp_data, rsp_id, rsp_err); end
`ifdef SIMPLE_BIT_OPS_ARB_PERF_EN
    checks++; if (perf_cnt0 !== 16'd0 || perf_cnt1 !== 16'd0) begin errors++;
      $display("FAIL reset_perf got=%h/%h required=0/0", perf_cnt0, perf_cnt1); end
`endif
    apply_reset();
  endtask

  task automatic test_basic();
    logic g0, g1, vld, id, e; logic [W-1:0] d; bit early, ok;
    run_one(1, 0, 3'd0, 3'd0, 4'hC, 4'hA, 4'h0, 4'h0, 0, 0, g0, g1, early, vld, d, id, e, ok);
    checks++; if ({g0, g1} !== 2'b10) begin errors++; $display("FAIL basic_grant got=%b required=10", {g0, g1}); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL basic_latency got=early required=2 cycles"); end
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b required=1", vld); end
    checks++; if (d !== 4'h8) begin errors++; $display("FAIL basic_data got=%h required=8", d); end
    checks++; if (id !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL basic_id_err got=%b/%b required=0/0", id, e); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_handshake got=%b required=1", ok); end
    tb_rr = 1'b1;
  endtask

  task automatic test_round_robin();
    logic g0, g1, vld, id, e; logic [W-1:0] d; bit early, ok;
    logic [W-1:0] exp_d [4] = '{4'h3, 4'hA, 4'h3, 4'hA};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      run_one(1, 1, 3'd2, 3'd3, 4'h1, 4'h2, 4'h5, 4'h0, 0, 1, g0, g1, early, vld, d, id, e, ok);
      checks++; if ({g0, g1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++;
        $display("FAIL rr_grant[%0d] got=%b required=%b", k, {g0, g1}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      checks++; if (vld !== 1'b1 || d !== exp_d[k] || id !== 1'(k % 2) || early !== 1'b0 || ok !== 1'b1) begin errors++;
        $display("FAIL rr_resp[%0d] got=%b/%h/%b required=1/%h/%0d", k, vld, d, id, exp_d[k], k % 2); end
    end
    tb_rr = 1'b0;
  endtask

  task automatic test_reductions();
    logic g0, g1, vld, id, e; logic [W-1:0] d; bit early, ok;
    logic [W-1:0] av [3] = '{4'hF, 4'h7, 4'h0};
    logic [W-1:0] exp_r [9] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0};
    for (int o = 0; o < 3; o++) begin
      for (int k = 0; k < 3; k++) begin
        run_one(0, 1, 3'd0, 3'(4 + o), 4'h0, 4'h0, av[k], W'($urandom), 0, 0,
                g0, g1, early, vld, d, id, e, ok);
        checks++; if (vld !== 1'b1 || d !== exp_r[o*3+k] || e !== 1'b0 || g1 !== 1'b1 || ok !== 1'b1) begin errors++;
          $display("FAIL reduce op=%0d a=%h got=%b/%h/%b required=1/%h/0", 4 + o, av[k], vld, d, e, exp_r[o*3+k]); end
      end
    end
    tb_rr = 1'b0;
  endtask

  task automatic test_illegal_stall();
    logic g0, g1, vld, id, e; logic [W-1:0] d; bit early, ok;
    run_one(0, 1, 3'd0, 3'd7, 4'h0, 4'h0, 4'hF, 4'hF, 5, 0, g0, g1, early, vld, d, id, e, ok);
    checks++; if ({g0, g1} !== 2'b01) begin errors++; $display("FAIL illegal_grant got=%b required=01", {g0, g1}); end
    checks++; if (vld !== 1'b1 || d !== 4'h0 || e !== 1'b1 || id !== 1'b1) begin errors++;
      $display("FAIL illegal_resp got=%b/%h/%b/%b required=1/0/1/1", vld, d, e, id); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL illegal_stall_stable got=%b required=1", ok); end
    tb_rr = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    logic g0, g1, vld, id, e; logic [W-1:0] d; bit early, ok, seen;
    run_one(1, 1, 3'd1, 3'd1, 4'h3, 4'h5, 4'h0, 4'h0, 0, 0, g0, g1, early, vld, d, id, e, ok);
    checks++; if ({g0, g1} !== 2'b10 || d !== 4'h6) begin errors++;
      $display("FAIL mid_pre got=%b/%h required=10/6", {g0, g1}, d); end
    @(negedge clock);
    req0_valid = 1'b1; req1_valid = 1'b1; req1_op = 3'd3; req1_a = 4'h0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++;
      $display("FAIL mid_grant got=%b required=01", {req0_ready, req1_ready}); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if ({rsp_valid, rsp_data, rsp_id, rsp_err, req0_ready, req1_ready} !== '0) begin errors++;
      $display("FAIL mid_async_clear got=%b/%h/%b/%b/%b%b required=all 0",
               rsp_valid, rsp_data, rsp_id, rsp_err, req0_ready, req1_ready); end
    @(negedge clock);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_resp got=response required=none"); end
    tb_rr = 1'b0;
    run_one(1, 1, 3'd2, 3'd0, 4'h9, 4'h4, 4'hF, 4'hF, 0, 0, g0, g1, early, vld, d, id, e, ok);
    checks++; if ({g0, g1} !== 2'b10 || d !== 4'hD || id !== 1'b0) begin errors++;
      $display("FAIL mid_after_grant got=%b/%h/%b required=10/d/0", {g0, g1}, d, id); end
    tb_rr = 1'b1;
  endtask

  task automatic test_random();
    logic g0, g1, vld, id, e, v0, v1, exp_id, exp_e; logic [W-1:0] d, exp_d;
    logic [2:0] op0, op1; logic [W-1:0] a0, b0, a1, b1;
    bit early, ok; int vv, stall;
    for (int n = 0; n < 40; n++) begin
      vv = $urandom_range(1, 3);
      v0 = vv[0]; v1 = vv[1];
      op0 = 3'($urandom); op1 = 3'($urandom);
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      stall = $urandom_range(0, 2);
      exp_id = (v0 && v1) ? tb_rr : v1;
      if (exp_id) model(op1, a1, b1, exp_d, exp_e);
      else        model(op0, a0, b0, exp_d, exp_e);
      run_one(v0, v1, op0, op1, a0, b0, a1, b1, stall, 1'($urandom), g0, g1, early, vld, d, id, e, ok);
      checks++; if ({g0, g1} !== {~exp_id, exp_id}) begin errors++;
        $display("FAIL rand_grant[%0d] got=%b required=%b", n, {g0, g1}, {~exp_id, exp_id}); end
      checks++; if (early !== 1'b0 || vld !== 1'b1) begin errors++;
        $display("FAIL rand_timing[%0d] got=early%b/valid%b required=0/1", n, early, vld); end
      checks++; if (d !== exp_d || e !== exp_e || id !== exp_id) begin errors++;
        $display("FAIL rand_resp[%0d] got=%h/%b/%b required=%h/%b/%b", n, d, e, id, exp_d, exp_e, exp_id); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_hold[%0d] got=%b required=1", n, ok); end
      tb_rr = ~exp_id;
    end
  endtask

`ifdef SIMPLE_BIT_OPS_ARB_PERF_EN
  task automatic test_perf();
    logic g0, g1, vld, id, e; logic [W-1:0] d; bit early, ok;
    logic [15:0] c0, c1;
    @(negedge clock); #1;
    c0 = perf_cnt0; c1 = perf_cnt1;
    for (int k = 0; k < 3; k++)
      run_one(0, 1, 3'd0, 3'd1, 4'h0, 4'h0, 4'h1, 4'h2, 0, 0, g0, g1, early, vld, d, id, e, ok);
    checks++; if (perf_cnt1 !== 16'(c1 + 16'd3) || perf_cnt0 !== c0) begin errors++;
      $display("FAIL perf_count got=%h/%h required=%h/%h", perf_cnt0, perf_cnt1, c0, 16'(c1 + 16'd3)); end
    tb_rr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_reductions();
    test_illegal_stall();
    test_reset_mid_exec();
    test_random();
`ifdef SIMPLE_BIT_OPS_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
